// File: rtl/rx_frame_fifo_if.sv
`default_nettype none
// ============================================================================
// Module      : rx_frame_fifo_if
// Description : Bundle of the receive-frame FIFO signals. The producer
//               (frame_dn/frame_err/frame_data), consumer handshake
//               (out_ready/out_valid/out_data/out_err), overflow clear and
//               status (count/full/empty/overflow) travel together.
//               Modport 'master' is the side that drives frames and the
//               consumer handshake; modport 'slave' is the FIFO itself.
// Ports       : none (signals only; clk/rst stay plain ports on the FIFO)
// Revision    : 1.0 - initial release
// ============================================================================
interface rx_frame_fifo_if #(
  parameter int FRAME_WIDTH = 8,
  parameter int DEPTH_LOG2  = 2
);

  // Producer side
  logic                   frame_dn;
  logic                   frame_err;
  logic [FRAME_WIDTH-1:0] frame_data;

  // Consumer side
  logic                   out_ready;
  logic                   clr_ovf;
  logic                   out_valid;
  logic [FRAME_WIDTH-1:0] out_data;
  logic                   out_err;

  // Status
  logic [DEPTH_LOG2:0]    count;
  logic                   full;
  logic                   empty;
  logic                   overflow;

  modport master (
    output frame_dn, frame_err, frame_data, out_ready, clr_ovf,
    input  out_valid, out_data, out_err, count, full, empty, overflow
  );

  modport slave (
    input  frame_dn, frame_err, frame_data, out_ready, clr_ovf,
    output out_valid, out_data, out_err, count, full, empty, overflow
  );

endinterface : rx_frame_fifo_if
`default_nettype wire

// File: rtl/rx_frame_fifo.sv
`default_nettype none
// ============================================================================
// Module      : rx_frame_fifo
// Description : First-word-fall-through FIFO for received serial frames.
//               Each entry holds {frame_err, frame_data}. A frame arriving
//               while the FIFO is full and not being popped is dropped and
//               raises a sticky overflow flag, cleared by clr_ovf (a drop on
//               the same edge wins).
// Ports       : clk  - single clock, rising edge
//               rst  - synchronous, active-high reset
//               bus  - rx_frame_fifo_if.slave:
//                        frame_dn/frame_err/frame_data : frame input
//                        out_ready                     : consumer accepts head
//                        clr_ovf                       : clear overflow flag
//                        out_valid/out_data/out_err    : head entry
//                        count/full/empty/overflow     : status
// Revision    : 1.0 - initial release
// ============================================================================
module rx_frame_fifo #(
  parameter int FRAME_WIDTH = 8,
  parameter int DEPTH_LOG2  = 2
) (
  input  wire              clk,
  input  wire              rst,
  rx_frame_fifo_if.slave   bus
);

  localparam int                  c_DEPTH     = 1 << DEPTH_LOG2;
  localparam int                  c_ENTRY_W   = FRAME_WIDTH + 1;
  localparam logic [DEPTH_LOG2:0] c_COUNT_MAX = (DEPTH_LOG2+1)'(c_DEPTH);

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  // Storage is deliberately not reset: the output gating while empty keeps
  // stale contents invisible.
  logic [c_ENTRY_W-1:0]  r_mem [c_DEPTH];
  logic [DEPTH_LOG2-1:0] r_wr_ptr;
  logic [DEPTH_LOG2-1:0] r_rd_ptr;
  logic [DEPTH_LOG2:0]   r_count;
  logic                  r_overflow;

  // --------------------------------------------------------------------------
  // Status, derived only from the registered count
  // --------------------------------------------------------------------------
  logic w_full;
  logic w_empty;

  assign w_full  = (r_count == c_COUNT_MAX);
  assign w_empty = (r_count == '0);

  // --------------------------------------------------------------------------
  // Push / pop / drop decisions
  // --------------------------------------------------------------------------
  logic w_pop;
  logic w_push;
  logic w_drop;

  // out_ready is meaningless while nothing is held.
  assign w_pop  = !w_empty && bus.out_ready;

  // A pop on the same edge frees the slot, so a full FIFO still accepts.
  assign w_push = bus.frame_dn && (!w_full || w_pop);
  assign w_drop = bus.frame_dn && w_full && !w_pop;

  // --------------------------------------------------------------------------
  // Storage write
  // --------------------------------------------------------------------------
  // When full with a simultaneous pop, wr_ptr equals rd_ptr: the head is read
  // combinationally before the edge and overwritten at the edge, which is
  // exactly the freed slot.
  always_ff @(posedge clk) begin
    if (!rst && w_push) begin
      r_mem[r_wr_ptr] <= {bus.frame_err, bus.frame_data};
    end
  end

  // --------------------------------------------------------------------------
  // Pointers and occupancy
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + DEPTH_LOG2'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + DEPTH_LOG2'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (DEPTH_LOG2+1)'(1);
        2'b01:   r_count <= r_count - (DEPTH_LOG2+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Sticky overflow: a drop takes priority over a clear on the same edge.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_overflow <= 1'b0;
    end else if (w_drop) begin
      r_overflow <= 1'b1;
    end else if (bus.clr_ovf) begin
      r_overflow <= 1'b0;
    end
  end

  // --------------------------------------------------------------------------
  // Head entry (fall-through), forced to zero while empty
  // --------------------------------------------------------------------------
  logic [c_ENTRY_W-1:0] w_head;

  assign w_head = w_empty ? '0 : r_mem[r_rd_ptr];

  assign bus.out_valid = !w_empty;
  assign bus.out_data  = w_head[FRAME_WIDTH-1:0];
  assign bus.out_err   = w_head[FRAME_WIDTH];
  assign bus.count     = r_count;
  assign bus.full      = w_full;
  assign bus.empty     = w_empty;
  assign bus.overflow  = r_overflow;

endmodule : rx_frame_fifo
`default_nettype wire
